// File: rtl/ev2_pcie_sink.sv
// ev2 event-write receiver: packs 16-bit event words into DWs, buffers them in a
// first-word-fall-through FIFO and runs the flush / flush-acknowledge handshake.
module ev2_pcie_sink #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned FULL_MARGIN = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] ev2_dat_i,
    input  logic        ev2_wr_i,
    output logic [15:0] ev2_count_o,
    output logic        ev2_full_o,
    input  logic        ev2_rst_i,
    output logic        ev2_rst_ack_o,
    output logic [31:0] dat_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overflow_o
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned CW    = (DEPTH_LOG2 + 2 > 17) ? DEPTH_LOG2 + 2 : 17;

    typedef enum logic {EMPTY_HALF, HAVE_LOW} pack_e;
    typedef enum logic [1:0] {IDLE, FLUSH, ACK} flush_e;

    pack_e         pack_q, pack_d;
    flush_e        flush_q, flush_d;
    logic [15:0]   low_q, low_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   dat_q, dat_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          ack_q, ack_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   count_q, count_d;
    logic [31:0]   mem_q [DEPTH];

    logic          push_c, pop_c;
    logic [31:0]   push_dat_c;
    logic [PW-1:0] entries_c;
    logic [CW-1:0] words_c, free_c;

    // Next-state: flush FSM, packer, pointers, FWFT head and status flags
    always_comb begin
        flush_d    = flush_q;
        pack_d     = pack_q;
        low_d      = low_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        dat_d      = dat_q;
        valid_d    = 1'b0;
        push_c     = 1'b0;
        push_dat_c = {ev2_dat_i, low_q};
        pop_c      = valid_q & ready_i;

        unique case (flush_q)
            IDLE:    if (ev2_rst_i) flush_d = FLUSH;
            FLUSH:   flush_d = ACK;
            ACK:     if (!ev2_rst_i) flush_d = IDLE;
            default: flush_d = IDLE;
        endcase

        if (ev2_wr_i && full_q) begin
            ovf_d = 1'b1;
        end else if (ev2_wr_i) begin
            if (pack_q == EMPTY_HALF) begin
                low_d  = ev2_dat_i;
                pack_d = HAVE_LOW;
            end else begin
                push_c = 1'b1;
                pack_d = EMPTY_HALF;
            end
        end

        if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);

        if (flush_q == FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pack_d   = EMPTY_HALF;
            low_d    = '0;
            ovf_d    = 1'b0;
        end

        // Head register tracks RAM at the next read pointer; the slot written this
        // cycle is still stale in RAM, so a pop onto it takes the pushed DW directly.
        valid_d = (rd_ptr_d != wr_ptr_q);
        if (valid_d) dat_d = mem_q[rd_ptr_d[DEPTH_LOG2-1:0]];
        if (pop_c && push_c && (rd_ptr_d == wr_ptr_q)) begin
            valid_d = 1'b1;
            dat_d   = push_dat_c;
        end
        if ((flush_q == FLUSH) || (flush_d == FLUSH)) valid_d = 1'b0;

        entries_c = wr_ptr_d - rd_ptr_d;
        words_c   = (CW'(entries_c) << 1) + CW'(pack_d == HAVE_LOW);
        free_c    = CW'(2 * DEPTH) - words_c;
        full_d    = (flush_d != IDLE) || (free_c <= CW'(FULL_MARGIN));
        count_d   = (words_c > CW'(16'hFFFF)) ? 16'hFFFF : words_c[15:0];
        ack_d     = (flush_d == ACK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pack_q   <= EMPTY_HALF;
            flush_q  <= IDLE;
            low_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dat_q    <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            pack_q   <= pack_d;
            flush_q  <= flush_d;
            low_q    <= low_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dat_q    <= dat_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage, no reset needed: pointers define what is valid
    always_ff @(posedge clk_i) begin
        if (push_c) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_dat_c;
    end

    assign ev2_count_o   = count_q;
    assign ev2_full_o    = full_q;
    assign ev2_rst_ack_o = ack_q;
    assign dat_o         = dat_q;
    assign valid_o       = valid_q;
    assign overflow_o    = ovf_q;

endmodule
